// File: rtl/id_ctrl_pkg.sv
// Shared types and constants for the ID-stage controller: control bundle,
// immediate-format select, opcode map and FSM state encoding.
package id_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned CTRL_W = 14;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'b1111;

    // result_src: 00 ALU, 01 load data, 10 PC+4, 11 CSR read data
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_CSR = 2'b11;

    typedef struct packed {
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             alu_src;
        logic [1:0]       result_src;
        logic             branch;
        logic             jump;
        logic [ALU_W-1:0] alu_ctrl;
        logic             csr_en;
        logic             illegal;
    } ctrl_t;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_CSR = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_ISSUE = 2'b10
    } state_e;

    function automatic imm_src_e imm_sel(input logic [OPC_W-1:0] opcode, input logic f3_msb);
        case (opcode)
            OPC_STORE:           return IMM_S;
            OPC_BRANCH:          return IMM_B;
            OPC_JAL:             return IMM_J;
            OPC_LUI, OPC_AUIPC:  return IMM_U;
            OPC_SYSTEM:          return f3_msb ? IMM_CSR : IMM_I;
            default:             return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/id_ctrl_if.sv
// ID-stage controller bus: pipeline inputs from IF/ID and hazard logic,
// decoded control and stall back out.
interface id_ctrl_if;
    import id_ctrl_pkg::*;

    logic [XLEN-1:0] instr_i;
    logic            instr_valid_i;
    logic            stall_i;
    logic            flush_i;
    logic            pipe_empty_i;
    logic [2:0]      imm_src_o;
    logic            id_stall_o;
    logic            ctrl_valid_o;
    ctrl_t           ctrl_o;

    modport master (
        output instr_i, instr_valid_i, stall_i, flush_i, pipe_empty_i,
        input  imm_src_o, id_stall_o, ctrl_valid_o, ctrl_o
    );

    modport slave (
        input  instr_i, instr_valid_i, stall_i, flush_i, pipe_empty_i,
        output imm_src_o, id_stall_o, ctrl_valid_o, ctrl_o
    );
endinterface

// File: rtl/id_ctrl_main_dec.sv
// Combinational opcode-to-control decode; unknown opcodes flag illegal only.
module main_dec
    import id_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic             rd_nz,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = {funct7_b5, funct3};
            end
            // Only the shift-right immediate uses funct7[5]; elsewhere it is immediate data
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = {funct7_b5 & (funct3 == 3'b101), funct3};
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
            end
            OPC_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OPC_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OPC_SYSTEM: begin
                if (funct3 != 3'b000) begin
                    ctrl.csr_en     = 1'b1;
                    ctrl.reg_write  = rd_nz;
                    ctrl.result_src = RES_CSR;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl.sv
// ID-stage controller: decode, CSR serialisation FSM (drain pipe before a
// CSR op issues) and the ID/EX control register.
module id_ctrl
    import id_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    id_ctrl_if.slave  bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d, dec;
    logic   valid_q, valid_d;
    logic   stall_c;
    logic   is_csr;
    logic   unused_instr_bits;

    main_dec u_main_dec (
        .opcode    (bus.instr_i[6:0]),
        .funct3    (bus.instr_i[14:12]),
        .funct7_b5 (bus.instr_i[30]),
        .rd_nz     (|bus.instr_i[11:7]),
        .ctrl      (dec)
    );

    assign unused_instr_bits = ^{bus.instr_i[31], bus.instr_i[29:15]};

    assign is_csr = bus.instr_valid_i && (bus.instr_i[6:0] == OPC_SYSTEM)
                    && (bus.instr_i[14:12] != 3'b000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    // Next state / ID-EX load; flush overrides everything, stall holds the register
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        stall_c = 1'b0;
        if (bus.flush_i) begin
            state_d = ST_RUN;
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.stall_i) begin
                        stall_c = 1'b1;
                    end else if (is_csr) begin
                        stall_c = 1'b1;
                        ctrl_d  = '0;
                        valid_d = 1'b0;
                        state_d = ST_DRAIN;
                    end else if (bus.instr_valid_i) begin
                        ctrl_d  = dec;
                        valid_d = 1'b1;
                    end else begin
                        ctrl_d  = '0;
                        valid_d = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    stall_c = 1'b1;
                    if (!bus.stall_i) begin
                        ctrl_d  = '0;
                        valid_d = 1'b0;
                    end
                    if (bus.pipe_empty_i) begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    stall_c = bus.stall_i;
                    if (!bus.stall_i) begin
                        ctrl_d  = dec;
                        valid_d = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    ctrl_d  = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.imm_src_o    = imm_sel(bus.instr_i[6:0], bus.instr_i[14]);
    assign bus.id_stall_o   = rst_n & stall_c;
    assign bus.ctrl_valid_o = valid_q;
    assign bus.ctrl_o       = ctrl_q;

endmodule

// File: tb/tb_id_ctrl.sv
// Self-checking bench for id_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_id_ctrl;
    import id_ctrl_pkg::*;

    localparam logic [31:0] I_ADDI   = 32'h00500093;
    localparam logic [31:0] I_SW     = 32'h00112023;
    localparam logic [31:0] I_CSRRWI = 32'h3400D073;
    localparam logic [31:0] I_ILL    = 32'h0000007F;

    logic clk;
    logic rst_n;
    id_ctrl_if bus ();

    id_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    // Model: 0 = normal flow, 1 = CSR waiting for empty pipe, 2 = CSR ready to go
    int    m_pend  = 0;
    logic  m_valid = 1'b0;
    ctrl_t m_ctrl  = '0;
    logic  last_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            7'b1110011:             return ins[14] ? 3'b111 : 3'b000;
            default:                return 3'b000;
        endcase
    endfunction

    // Expected control bundle straight from the instruction-class table
    function automatic ctrl_t ref_dec(input logic [31:0] ins);
        ctrl_t c;
        logic [2:0] f3;
        c  = '0;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0000011: begin c.reg_write = 1; c.mem_read = 1; c.alu_src = 1; c.result_src = 2'b01; end
            7'b0100011: begin c.mem_write = 1; c.alu_src = 1; end
            7'b0110011: begin c.reg_write = 1; c.alu_ctrl = {ins[30], f3}; end
            7'b0010011: begin
                c.reg_write = 1; c.alu_src = 1;
                c.alu_ctrl = (f3 == 3'b101) ? {ins[30], f3} : {1'b0, f3};
            end
            7'b1100011: begin c.branch = 1; c.alu_ctrl = 4'b1000; end
            7'b1101111: begin c.reg_write = 1; c.jump = 1; c.result_src = 2'b10; end
            7'b1100111: begin c.reg_write = 1; c.jump = 1; c.alu_src = 1; c.result_src = 2'b10; end
            7'b0110111: begin c.reg_write = 1; c.alu_src = 1; c.alu_ctrl = 4'b1111; end
            7'b0010111: begin c.reg_write = 1; c.alu_src = 1; end
            7'b1110011: if (f3 != 0) begin
                c.csr_en = 1; c.result_src = 2'b11; c.reg_write = (ins[11:7] != 0);
            end
            default: c.illegal = 1;
        endcase
        return c;
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registers
    task automatic cycle(input logic rn, input logic fl, input logic st,
                         input logic iv, input logic pe, input logic [31:0] ins);
        logic exp_stall;
        logic csr;
        @(negedge clk);
        rst_n             = rn;
        bus.flush_i       = fl;
        bus.stall_i       = st;
        bus.instr_valid_i = iv;
        bus.pipe_empty_i  = pe;
        bus.instr_i       = ins;
        #1;
        csr = iv && (ins[6:0] == 7'b1110011) && (ins[14:12] != 0);
        if (!rn || fl)        exp_stall = 1'b0;
        else if (m_pend == 0) exp_stall = st || csr;
        else if (m_pend == 1) exp_stall = 1'b1;
        else                  exp_stall = st;
        check("imm_src", 32'(bus.imm_src_o), 32'(ref_imm(ins)));
        check("id_stall", 32'(bus.id_stall_o), 32'(exp_stall));
        last_stall = exp_stall;
        if (!rn || fl) begin
            m_pend = 0; m_valid = 1'b0; m_ctrl = '0;
        end else if (m_pend == 0) begin
            if (!st) begin
                if (csr) begin
                    m_pend = 1; m_valid = 1'b0; m_ctrl = '0;
                end else if (iv) begin
                    m_valid = 1'b1; m_ctrl = ref_dec(ins);
                end else begin
                    m_valid = 1'b0; m_ctrl = '0;
                end
            end
        end else if (m_pend == 1) begin
            if (!st) begin m_valid = 1'b0; m_ctrl = '0; end
            if (pe) m_pend = 2;
        end else if (!st) begin
            m_valid = 1'b1; m_ctrl = ref_dec(ins); m_pend = 0;
        end
        @(posedge clk);
        #1;
        check("ctrl_valid", 32'(bus.ctrl_valid_o), 32'(m_valid));
        check("ctrl", 32'(bus.ctrl_o), 32'(m_ctrl));
    endtask

    initial begin
        ctrl_t held;
        logic [31:0] ins;
        logic [31:0] r;
        logic iv;
        rst_n             = 1'b0;
        bus.flush_i       = 1'b1;
        bus.stall_i       = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.pipe_empty_i  = 1'b0;
        bus.instr_i       = I_ADDI;

        // Reset dominates flush and stall
        repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, I_ADDI);
        check("rst_ctrl_zero", 32'(bus.ctrl_o), 32'd0);

        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_ADDI);
        check("addi_reg_write", 32'(bus.ctrl_o.reg_write), 32'd1);
        check("addi_alu_src", 32'(bus.ctrl_o.alu_src), 32'd1);

        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_SW);
        check("sw_mem_write", 32'(bus.ctrl_o.mem_write), 32'd1);
        check("sw_reg_write", 32'(bus.ctrl_o.reg_write), 32'd0);

        // CSR: RUN + two DRAIN cycles with pipe busy, DRAIN with empty, ISSUE
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_CSRRWI);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, I_CSRRWI);
        check("csr_bubble", 32'(bus.ctrl_valid_o), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, I_CSRRWI);
        check("csr_valid", 32'(bus.ctrl_valid_o), 32'd1);
        check("csr_en", 32'(bus.ctrl_o.csr_en), 32'd1);
        check("csr_rd0_no_write", 32'(bus.ctrl_o.reg_write), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, I_ADDI);
        check("after_csr_run", 32'(bus.ctrl_o.csr_en), 32'd0);

        // Flush while draining kills the CSR
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_CSRRWI);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_CSRRWI);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, I_CSRRWI);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, I_ADDI);
        check("flush_no_issue", 32'(bus.ctrl_valid_o), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, I_ADDI);
        check("flush_back_run", 32'(bus.ctrl_o.csr_en), 32'd0);

        // Stall hold, then illegal opcode
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_ADDI);
        held = bus.ctrl_o;
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, I_SW);
        check("stall_hold", 32'(bus.ctrl_o), 32'(held));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_ILL);
        check("illegal_only", 32'(bus.ctrl_o), 32'h1);

        // Reset mid-drain abandons the CSR
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_CSRRWI);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I_CSRRWI);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, I_CSRRWI);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, I_ADDI);
        check("rst_drain_no_issue", 32'(bus.ctrl_valid_o), 32'd0);

        // Random traffic; IF/ID holds its contents while id_stall is expected
        ins = I_ADDI;
        iv  = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!last_stall) begin
                r = $urandom();
                case ($urandom_range(0, 11))
                    0:       ins = {r[31:7], 7'b0000011};
                    1:       ins = {r[31:7], 7'b0010011};
                    2:       ins = {r[31:7], 7'b0010111};
                    3:       ins = {r[31:7], 7'b0100011};
                    4:       ins = {r[31:7], 7'b0110011};
                    5:       ins = {r[31:7], 7'b0110111};
                    6:       ins = {r[31:7], 7'b1100011};
                    7:       ins = {r[31:7], 7'b1100111};
                    8:       ins = {r[31:7], 7'b1101111};
                    9, 10:   ins = {r[31:7], 7'b1110011};
                    default: ins = r;
                endcase
                iv = ($urandom_range(0, 7) != 0);
            end
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 4) == 0), iv, ($urandom_range(0, 2) == 0), ins);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
